// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared constants for the iterative multiplier.
//   ST_*        FSM state encodings (2 bits, IDLE=0 BUSY=1 FIX=2 DONE=3)
//   cnt_width() width of the digit counter for a given WIDTH/STEP pair;
//               one bit wider than strictly needed so it can hold N itself.
package seq_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int cnt_width(input int width, input int step);
        return $clog2(width / step) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_pp.sv
// seq_mult_pp: combinational partial-product generator.
//   ma_i     WIDTH-bit unsigned multiplicand magnitude
//   digit_i  STEP-bit multiplier digit
//   shift_i  digit weight (bit position of the digit's LSB)
//   pp_o     (ma_i * digit_i) << shift_i, 2*WIDTH bits
module seq_mult_pp #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0]   ma_i,
    input  logic [STEP-1:0]    digit_i,
    input  logic [SHW-1:0]     shift_i,
    output logic [2*WIDTH-1:0] pp_o
);

    logic [2*WIDTH-1:0] ma_ext;
    logic [2*WIDTH-1:0] digit_ext;
    logic [2*WIDTH-1:0] prod;

    assign ma_ext    = {{WIDTH{1'b0}}, ma_i};
    assign digit_ext = {{(2*WIDTH-STEP){1'b0}}, digit_i};
    // ma * d fits in WIDTH+STEP bits, so the 2*WIDTH product never truncates.
    assign prod      = ma_ext * digit_ext;
    assign pp_o      = prod << shift_i;

endmodule

// File: rtl/seq_mult.sv
// seq_mult: iterative signed/unsigned multiplier, STEP multiplier bits per cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, signed_mode)
//   out_valid/out_ready product handshake (p)
//   busy                high while in BUSY or FIX
//   dbg_state_o         current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds its data stable while valid is high and not yet
// accepted; ready never depends combinationally on valid.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);

    localparam int N   = WIDTH / STEP;
    localparam int CW  = cnt_width(WIDTH, STEP);
    localparam int SHW = $clog2(2 * WIDTH);
    localparam int PW  = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [SHW-1:0]   shift;
    logic [PW-1:0]    pp;

    // Negation is modulo 2^WIDTH, so the most-negative value maps onto its
    // exact unsigned magnitude 2^(WIDTH-1).
    assign a_mag = (signed_mode && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // mb_q is shifted down one digit per BUSY cycle, so its low STEP bits are
    // always the digit at position count*STEP of the original multiplier.
    assign shift = SHW'(cnt_q) * SHW'(STEP);

    seq_mult_pp #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SHW   (SHW)
    ) u_pp (
        .ma_i    (ma_q),
        .digit_i (mb_q[STEP-1:0]),
        .shift_i (shift),
        .pp_o    (pp)
    );

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ma_d    = a_mag;
                    mb_d    = b_mag;
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_q + pp;
                mb_d  = mb_q >> STEP;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                p_d     = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q == ST_BUSY) || (state_q == ST_FIX);
    assign p           = p_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed bench for seq_mult with three configurations
// (WIDTH=4/STEP=1, WIDTH=8/STEP=1, WIDTH=8/STEP=2) sharing one clock/reset.
module tb_seq_mult;

    logic clk;
    logic rst_n;

    logic       iv   [3];
    logic       ordy [3];
    logic       sm   [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       bz   [3];
    logic [1:0] st   [3];

    logic [3:0]  a0, b0;
    logic [7:0]  p0;
    logic [7:0]  a1, b1, a2, b2;
    logic [15:0] p1, p2;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4), .STEP(1)) u_w4s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a0), .b(b0), .signed_mode(sm[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .p(p0), .busy(bz[0]), .dbg_state_o(st[0])
    );

    seq_mult #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a1), .b(b1), .signed_mode(sm[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .p(p1), .busy(bz[1]), .dbg_state_o(st[1])
    );

    seq_mult #(.WIDTH(8), .STEP(2)) u_w8s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a2), .b(b2), .signed_mode(sm[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .p(p2), .busy(bz[2]), .dbg_state_o(st[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_in(input int k, input logic v, input logic [7:0] aa,
                          input logic [7:0] bb, input logic s);
        case (k)
            0: begin iv[0] = v; a0 = aa[3:0]; b0 = bb[3:0]; sm[0] = s; end
            1: begin iv[1] = v; a1 = aa; b1 = bb; sm[1] = s; end
            default: begin iv[2] = v; a2 = aa; b2 = bb; sm[2] = s; end
        endcase
    endtask

    function automatic logic [15:0] get_p(input int k);
        case (k)
            0:       return {8'h00, p0};
            1:       return p1;
            default: return p2;
        endcase
    endfunction

    // Present one operation, wait (bounded) for out_valid, check latency and
    // product, then complete the output handshake.
    task automatic run_op(input string tag, input int k, input logic [7:0] aa,
                          input logic [7:0] bb, input logic s,
                          input logic [15:0] exp_p, input int exp_lat);
        int cycles;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(ir[k]), 32'd1);
        set_in(k, 1'b1, aa, bb, s);
        @(posedge clk);
        #1;
        set_in(k, 1'b0, 8'h00, 8'h00, 1'b0);
        check({tag, "_busy"}, 32'(bz[k]), 32'd1);
        cycles = 0;
        while (!ov[k] && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_p"}, 32'(get_p(k)), 32'(exp_p));
        check({tag, "_state_done"}, 32'(st[k]), 32'd3);
        @(negedge clk);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        check({tag, "_out_drop"}, 32'(ov[k]), 32'd0);
        check({tag, "_idle"}, 32'(st[k]), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_ir%0d", tag, k), 32'(ir[k]), 32'd1);
            check($sformatf("%s_ov%0d", tag, k), 32'(ov[k]), 32'd0);
            check($sformatf("%s_bz%0d", tag, k), 32'(bz[k]), 32'd0);
            check($sformatf("%s_st%0d", tag, k), 32'(st[k]), 32'd0);
            check($sformatf("%s_p%0d", tag, k), 32'(get_p(k)), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int seen_ov;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(k, 1'b0, 8'h00, 8'h00, 1'b0);
            ordy[k] = 1'b0;
        end
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // main function, several configurations and modes
        run_op("w4_uns_15x15",   0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 5);
        run_op("w8_sgn_m128sq",  1, 8'h80, 8'h80, 1'b1, 16'h4000, 9);
        run_op("w8_sgn_m8x7",    1, 8'hF8, 8'h07, 1'b1, 16'hFFC8, 9);
        run_op("w8_uns_248x7",   1, 8'hF8, 8'h07, 1'b0, 16'h06C8, 9);
        run_op("s2_uns_200x3",   2, 8'hC8, 8'h03, 1'b0, 16'h0258, 5);
        run_op("s2_uns_200x0",   2, 8'hC8, 8'h00, 1'b0, 16'h0000, 5);
        run_op("s2_sgn_m128x127",2, 8'h80, 8'h7F, 1'b1, 16'hC080, 5);

        // back-pressure: hold out_ready low, poke a second operation
        @(negedge clk);
        set_in(2, 1'b1, 8'd13, 8'd11, 1'b0);
        @(posedge clk);
        #1;
        set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
        cycles = 0;
        while (!ov[2] && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("bp_latency", 32'(cycles), 32'd5);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) set_in(2, 1'b1, 8'd5, 8'd5, 1'b0);
            if (i == 6) set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("bp_ov_%0d", i), 32'(ov[2]), 32'd1);
            check($sformatf("bp_p_%0d", i), 32'(p2), 32'h008F);
            check($sformatf("bp_ir_%0d", i), 32'(ir[2]), 32'd0);
        end
        @(negedge clk);
        ordy[2] = 1'b1;
        @(posedge clk);
        #1;
        ordy[2] = 1'b0;
        check("bp_release_idle", 32'(st[2]), 32'd0);
        check("bp_release_ir", 32'(ir[2]), 32'd1);
        run_op("bp_second_5x5", 2, 8'd5, 8'd5, 1'b0, 16'd25, 5);

        // reset asserted mid-operation
        @(negedge clk);
        set_in(1, 1'b1, 8'd9, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(bz[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ir_after", 32'(ir[1]), 32'd1);
        seen_ov = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (ov[1]) seen_ov = 1;
        end
        check("midrst_no_ov", 32'(seen_ov), 32'd0);
        run_op("midrst_6x7", 1, 8'd6, 8'd7, 1'b0, 16'd42, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
